ising_coupled_cell: RTL and testbench
=====================================

# ising_coupled_cell

Single cell of the Ising coupling matrix. It is a clocked, discrete-time model of the ring-oscillator interaction: horizontal (spin i) and vertical (spin j) phase signals pass through per-path delay lines. With DIAGONAL=0 the cell is a coupled cell, and each path's delay is modulated by an AXI-programmed weight and by spin agreement. With DIAGONAL=1 the cell is a shorted cell that turns the row signal back into the column. `recursive_matrix` instantiates it as its N=1 leaf.

## Interface
- `NUM_WEIGHTS`, 5: number of weight levels; odd, ≥3. C = (NUM_WEIGHTS-1)/2 is the zero-coupling weight.
- `NUM_LUTS`, 2: shorted-cell turnaround delay in cycles; ≥1.
- `DIAGONAL`, 0: 0 = coupled cell, 1 = shorted cell.
- `clk` in 1: single clock; all state on rising edge.
- `axi_rst` in 1: reset, synchronous, active-high.
- `ising_rstn` in 1: oscillator hold, active-low. Sampled synchronously; does not touch the weight register.
- `lin`, `rin`, `tin`, `bin` in 1 each: phase inputs from left, right, top, bottom.
- `lout`, `rout`, `tout`, `bout` out 1 each: phase outputs to left, right, top, bottom.
- `wready` in 1: AXI write strobe.
- `wr_addr_match` in 1: this cell is addressed.
- `vh` in 1: coupled-axis select.
- `wdata` in 32: write data.
- `rdata` out 32: read data, combinational.

## Operation
- Weight register `w`, width WW = $clog2(NUM_WEIGHTS):
  - Loaded when `wready & wr_addr_match` is high at a clock edge.
  - Loaded value is `wdata[WW-1:0]`, clamped to NUM_WEIGHTS-1.
  - `rdata = {zero pad, w}`.
  - In a shorted cell, writes are ignored and `rdata = 0`.
- Each path has a shift register `sr[0..NUM_WEIGHTS-1]`: `sr[0]` <= input, `sr[k]` <= `sr[k-1]`. The output is `sr[D-1]`, giving a delay of D cycles.
- Coupled paths and their compare partners:
  - `lin`→`rout`, compared with `tin`.
  - `rin`→`lout`, compared with `bin`.
  - `tin`→`bout`, compared with `lin`.
  - `bin`→`tout`, compared with `rin`.
- Delay of a modulated path:
  - a = +1 if `sr[0]` of the path equals `sr[0]` of its partner, else -1.
  - D = C + 1 - a·(w - C), range 1..NUM_WEIGHTS.
- `vh` selects which paths are modulated:
  - `vh`=0: horizontal paths modulated; vertical paths fixed at D = C+1.
  - `vh`=1: the reverse.
- Shorted cell (DIAGONAL=1):
  - `tout` = ~`rin` delayed NUM_LUTS cycles.
  - `rout` = `tin` delayed NUM_LUTS cycles.
  - `lin` and `bin` are ignored; `lout` = `bout` = 0.
- `ising_rstn`=0 at an edge clears all shift registers. All outputs are forced to 0 combinationally while it is low, including the inverted `tout`.

## Timing
- `axi_rst`: `w` = C; all shift registers = 0; `rdata` = C (coupled) or 0 (shorted).
- Output reset values: coupled `tout`/`rout`/`lout`/`bout` = 0. Shorted `tout` = 1 after reset if `ising_rstn`=1; all other shorted outputs = 0.
- Write latency: `rdata` reflects the new value 1 cycle after the write edge.
- A write and `axi_rst` in the same cycle: reset wins.
- D is computed from registered values only, so there are no combinational input→output paths besides `rdata` and the hold force.
- If D changes, the output switches taps the same cycle. Pulse duplication or loss from this is allowed.
- `ising_rstn` asserted mid-operation: outputs read 0 from that cycle; on release, delay lines refill from 0.

## Structure
- Shared package `ising_pkg`:
  - `WW(NUM_WEIGHTS)`.
  - Zero-weight constant C.
  - Weight clamp function.
- Sub-module `cell_delay_line`:
  - Parameter DEPTH.
  - Ports: `clk`, `clr`, `din`, `tap`, `dout`.
- Instantiation count:
  - Four instances in a coupled cell (DEPTH = NUM_WEIGHTS).
  - Two in a shorted cell (DEPTH = NUM_LUTS, fixed tap).
  - Selected by a generate on DIAGONAL.

## Test plan
All scenarios use NUM_WEIGHTS=5 (C=2) and NUM_LUTS=2.
- Reset: `axi_rst` 1 cycle → `rdata`=2, all coupled outputs 0. Shorted `rdata`=0, `tout`=1.
- Writes:
  - `wdata`=4 with match → `rdata`=4 next cycle.
  - `wdata`=1 without match → unchanged.
  - `wdata`=7 → `rdata`=4 (clamped).
- w=2, `vh`=0: `lin` 0→1 with `tin`=0 → `rout` rises exactly 3 cycles later. `tin` 0→1 → `bout` rises 3 cycles later.
- w=4, `vh`=0:
  - `lin` and `tin` step 0→1 together → `rout` rises after 1 cycle; `bout` after 3 cycles.
  - `lin` steps with `tin`=0 → `rout` rises after 5 cycles.
  - Repeat with w=0 → 5 cycles and 1 cycle respectively.
- Shorted: `rin` 0→1 → `tout` falls 2 cycles later. `tin` 0→1 → `rout` rises 2 cycles later.
- Hold: drop `ising_rstn` while toggling inputs → outputs 0 from that cycle and `w` retained. After release, a `lin` step with w=2 propagates in 3 cycles.

Source files
------------

// File: rtl/ising_pkg.sv
// Shared sizing helpers for the Ising coupling matrix cells.
//   ww()           - bit width needed to index n levels (minimum 1)
//   zero_weight()  - weight code that gives zero coupling
//   clamp_weight() - limit a raw weight code to the legal range
package ising_pkg;

  function automatic int unsigned ww(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned zero_weight(input int unsigned n);
    return (n - 1) / 2;
  endfunction

  function automatic int unsigned clamp_weight(input int unsigned raw, input int unsigned n);
    return (raw > n - 1) ? n - 1 : raw;
  endfunction

endpackage

// File: rtl/cell_delay_line.sv
// Tapped shift register that models one oscillator path delay.
//   clk  - clock
//   clr  - synchronous clear of all stages
//   din  - phase input, captured into stage 0
//   tap  - stage selected for output (delay = tap + 1 cycles)
//   dout - selected stage
module cell_delay_line
  import ising_pkg::*;
#(
  parameter int unsigned DEPTH = 5
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   din,
  input  logic [ww(DEPTH)-1:0]   tap,
  output logic                   dout
);

  localparam int unsigned TW = ww(DEPTH);
  localparam int unsigned PW = 1 << TW;

  logic [DEPTH-1:0] sr;
  logic [PW-1:0]    padded;

  // Shift chain; loop form keeps DEPTH=1 legal.
  always_ff @(posedge clk) begin
    if (clr) begin
      sr <= '0;
    end else begin
      sr[0] <= din;
      for (int k = 1; k < DEPTH; k++) begin
        sr[k] <= sr[k-1];
      end
    end
  end

  // Pad to a power of two so every tap code has a defined stage.
  assign padded = PW'(sr);
  assign dout   = padded[tap];

endmodule

// File: rtl/ising_coupled_cell.sv
// One cell of the Ising coupling matrix.
// Coupled cell (DIAGONAL=0): four delay lines whose delay depends on the
// programmed weight and on whether each path agrees with its partner spin.
// Shorted cell (DIAGONAL=1): row phase is turned back into the column.
//   clk, axi_rst        - clock, synchronous active-high reset
//   ising_rstn          - oscillator hold (active-low), keeps the weight
//   lin/rin/tin/bin     - phase inputs from left/right/top/bottom
//   lout/rout/tout/bout - phase outputs to left/right/top/bottom
//   wready, wr_addr_match, wdata - weight write port
//   vh                  - 0: horizontal paths coupled, 1: vertical paths
//   rdata               - weight readback (combinational)
module ising_coupled_cell
  import ising_pkg::*;
#(
  parameter int unsigned NUM_WEIGHTS = 5,
  parameter int unsigned NUM_LUTS    = 2,
  parameter int unsigned DIAGONAL    = 0
) (
  input  logic        clk,
  input  logic        axi_rst,
  input  logic        ising_rstn,
  input  logic        lin,
  input  logic        rin,
  input  logic        tin,
  input  logic        bin,
  output logic        lout,
  output logic        rout,
  output logic        tout,
  output logic        bout,
  input  logic        wready,
  input  logic        wr_addr_match,
  input  logic        vh,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);

  localparam int unsigned WW  = ww(NUM_WEIGHTS);
  localparam int unsigned C   = zero_weight(NUM_WEIGHTS);
  localparam int unsigned LTW = ww(NUM_LUTS);

  logic clr;
  assign clr = axi_rst | ~ising_rstn;

  if (DIAGONAL == 0) begin : g_coupled
    logic [WW-1:0] w;
    logic          vh_q;
    logic [3:0]    in_q;   // {bin, tin, rin, lin}: mirrors stage 0 of each line
    logic [WW-1:0] tap_l, tap_r, tap_t, tap_b;
    logic [WW-1:0] tap_agree;
    logic          d_l, d_r, d_t, d_b;
    logic          unused_bits;

    // Weight and axis select; reset has priority over a write.
    always_ff @(posedge clk) begin
      if (axi_rst) begin
        w    <= WW'(C);
        vh_q <= 1'b0;
      end else begin
        vh_q <= vh;
        if (wready && wr_addr_match) begin
          w <= WW'(clamp_weight(32'(wdata[WW-1:0]), NUM_WEIGHTS));
        end
      end
    end

    // Registered spins used for the agreement compare.
    always_ff @(posedge clk) begin
      if (clr) begin
        in_q <= '0;
      end else begin
        in_q <= {bin, tin, rin, lin};
      end
    end

    // tap = D-1: agree gives 2C-w, disagree gives w, unmodulated gives C.
    always_comb begin
      tap_agree = WW'(NUM_WEIGHTS - 1) - w;
      tap_l     = WW'(C);
      tap_r     = WW'(C);
      tap_t     = WW'(C);
      tap_b     = WW'(C);
      if (!vh_q) begin
        tap_l = (in_q[0] == in_q[2]) ? tap_agree : w;
        tap_r = (in_q[1] == in_q[3]) ? tap_agree : w;
      end else begin
        tap_t = (in_q[2] == in_q[0]) ? tap_agree : w;
        tap_b = (in_q[3] == in_q[1]) ? tap_agree : w;
      end
    end

    cell_delay_line #(.DEPTH(NUM_WEIGHTS)) u_line_l (
      .clk(clk), .clr(clr), .din(lin), .tap(tap_l), .dout(d_l));
    cell_delay_line #(.DEPTH(NUM_WEIGHTS)) u_line_r (
      .clk(clk), .clr(clr), .din(rin), .tap(tap_r), .dout(d_r));
    cell_delay_line #(.DEPTH(NUM_WEIGHTS)) u_line_t (
      .clk(clk), .clr(clr), .din(tin), .tap(tap_t), .dout(d_t));
    cell_delay_line #(.DEPTH(NUM_WEIGHTS)) u_line_b (
      .clk(clk), .clr(clr), .din(bin), .tap(tap_b), .dout(d_b));

    assign rout  = d_l & ising_rstn;
    assign lout  = d_r & ising_rstn;
    assign bout  = d_t & ising_rstn;
    assign tout  = d_b & ising_rstn;
    assign rdata = 32'(w);

    assign unused_bits = ^wdata[31:WW];
  end else begin : g_shorted
    logic d_t, d_r;
    logic unused_bits;

    // Fixed turnaround: right input back out the top (inverted), top out the right.
    cell_delay_line #(.DEPTH(NUM_LUTS)) u_line_rt (
      .clk(clk), .clr(clr), .din(rin), .tap(LTW'(NUM_LUTS - 1)), .dout(d_t));
    cell_delay_line #(.DEPTH(NUM_LUTS)) u_line_tr (
      .clk(clk), .clr(clr), .din(tin), .tap(LTW'(NUM_LUTS - 1)), .dout(d_r));

    // Inversion after the line so a cleared line reads 1 when not held.
    assign tout  = ~d_t & ising_rstn;
    assign rout  = d_r & ising_rstn;
    assign lout  = 1'b0;
    assign bout  = 1'b0;
    assign rdata = '0;

    assign unused_bits = ^{lin, bin, vh, wready, wr_addr_match, wdata};
  end

endmodule

// File: tb/tb_ising_coupled_cell.sv
module tb_ising_coupled_cell;

  localparam int S_RDC   = 0;
  localparam int S_LOUT  = 1;
  localparam int S_ROUT  = 2;
  localparam int S_TOUT  = 3;
  localparam int S_BOUT  = 4;
  localparam int S_RDS   = 5;
  localparam int S_TOUTS = 6;
  localparam int S_ROUTS = 7;
  localparam int S_LOUTS = 8;
  localparam int S_BOUTS = 9;

  logic        clk = 1'b0;
  logic        axi_rst, ising_rstn;
  logic        lin, rin, tin, bin;
  logic        wready, wr_addr_match, vh;
  logic [31:0] wdata;

  logic        lout_c, rout_c, tout_c, bout_c;
  logic [31:0] rdata_c;
  logic        lout_s, rout_s, tout_s, bout_s;
  logic [31:0] rdata_s;

  always #5 clk = ~clk;

  ising_coupled_cell #(.NUM_WEIGHTS(5), .NUM_LUTS(2), .DIAGONAL(0)) dut_c (
    .clk(clk), .axi_rst(axi_rst), .ising_rstn(ising_rstn),
    .lin(lin), .rin(rin), .tin(tin), .bin(bin),
    .lout(lout_c), .rout(rout_c), .tout(tout_c), .bout(bout_c),
    .wready(wready), .wr_addr_match(wr_addr_match), .vh(vh),
    .wdata(wdata), .rdata(rdata_c));

  ising_coupled_cell #(.NUM_WEIGHTS(5), .NUM_LUTS(2), .DIAGONAL(1)) dut_s (
    .clk(clk), .axi_rst(axi_rst), .ising_rstn(ising_rstn),
    .lin(lin), .rin(rin), .tin(tin), .bin(bin),
    .lout(lout_s), .rout(rout_s), .tout(tout_s), .bout(bout_s),
    .wready(wready), .wr_addr_match(wr_addr_match), .vh(vh),
    .wdata(wdata), .rdata(rdata_s));

  typedef struct {
    int          due;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   cycle  = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [31:0] sample(input int sig);
    case (sig)
      S_RDC:   return rdata_c;
      S_LOUT:  return 32'(lout_c);
      S_ROUT:  return 32'(rout_c);
      S_TOUT:  return 32'(tout_c);
      S_BOUT:  return 32'(bout_c);
      S_RDS:   return rdata_s;
      S_TOUTS: return 32'(tout_s);
      S_ROUTS: return 32'(rout_s);
      S_LOUTS: return 32'(lout_s);
      default: return 32'(bout_s);
    endcase
  endfunction

  function automatic string sig_name(input int sig);
    case (sig)
      S_RDC:   return "rdata_c";
      S_LOUT:  return "lout_c";
      S_ROUT:  return "rout_c";
      S_TOUT:  return "tout_c";
      S_BOUT:  return "bout_c";
      S_RDS:   return "rdata_s";
      S_TOUTS: return "tout_s";
      S_ROUTS: return "rout_s";
      S_LOUTS: return "lout_s";
      default: return "bout_s";
    endcase
  endfunction

  // Expected value for a signal, due at the falling edge off cycles from now.
  task automatic push_exp(input int off, input int sig, input logic [31:0] val);
    sb.push_back('{cycle + off, sig, val});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] d, input logic m);
    wdata         = d;
    wready        = 1'b1;
    wr_addr_match = m;
    tick(1);
    wready        = 1'b0;
    wr_addr_match = 1'b0;
  endtask

  // Monitor: compare every due expectation on the falling edge.
  always @(negedge clk) begin
    exp_t        keep[$];
    logic [31:0] act;
    keep = {};
    foreach (sb[i]) begin
      if (sb[i].due <= cycle) begin
        act = sample(sb[i].sig);
        checks++;
        if (act !== sb[i].val || sb[i].due < cycle) begin
          errors++;
          $display("FAIL %s cycle %0d got %0h want %0h (due %0d)",
                   sig_name(sb[i].sig), cycle, act, sb[i].val, sb[i].due);
        end
      end else begin
        keep.push_back(sb[i]);
      end
    end
    sb = keep;
  end

  initial begin
    axi_rst = 1'b1; ising_rstn = 1'b1;
    lin = 1'b0; rin = 1'b0; tin = 1'b0; bin = 1'b0;
    wready = 1'b0; wr_addr_match = 1'b0; vh = 1'b0; wdata = '0;
    tick(1);
    axi_rst = 1'b0;

    // Reset state
    push_exp(0, S_RDC, 2);  push_exp(0, S_ROUT, 0); push_exp(0, S_LOUT, 0);
    push_exp(0, S_TOUT, 0); push_exp(0, S_BOUT, 0); push_exp(0, S_RDS, 0);
    push_exp(0, S_TOUTS, 1); push_exp(0, S_ROUTS, 0);
    push_exp(0, S_LOUTS, 0); push_exp(0, S_BOUTS, 0);
    tick(1);

    // Weight writes
    wr(4, 1'b1); push_exp(0, S_RDC, 4); push_exp(0, S_RDS, 0);
    wr(1, 1'b0); push_exp(0, S_RDC, 4);
    wr(0, 1'b1); push_exp(0, S_RDC, 0);
    wr(7, 1'b1); push_exp(0, S_RDC, 4);
    axi_rst = 1'b1;
    wr(3, 1'b1);
    axi_rst = 1'b0;
    push_exp(0, S_RDC, 2); push_exp(0, S_TOUTS, 1);

    // w=2: fixed 3-cycle delay on both axes
    wr(2, 1'b1);
    lin = 1'b1;
    push_exp(2, S_ROUT, 0); push_exp(3, S_ROUT, 1);
    tick(4);
    tin = 1'b1;
    push_exp(2, S_BOUT, 0); push_exp(3, S_BOUT, 1);
    push_exp(1, S_ROUTS, 0); push_exp(2, S_ROUTS, 1);
    tick(4);
    lin = 1'b0; tin = 1'b0;
    tick(6);

    // w=4, agreeing step: horizontal 1 cycle, vertical fixed 3
    wr(4, 1'b1);
    lin = 1'b1; tin = 1'b1;
    push_exp(0, S_ROUT, 0); push_exp(1, S_ROUT, 1);
    push_exp(2, S_BOUT, 0); push_exp(3, S_BOUT, 1);
    tick(5);
    lin = 1'b0; tin = 1'b0;
    tick(6);

    // w=4, disagreeing step: 5 cycles
    lin = 1'b1;
    push_exp(4, S_ROUT, 0); push_exp(5, S_ROUT, 1);
    tick(6);
    lin = 1'b0;
    tick(6);

    // w=0: agreeing 5 cycles, disagreeing 1 cycle
    wr(0, 1'b1);
    lin = 1'b1; tin = 1'b1;
    push_exp(4, S_ROUT, 0); push_exp(5, S_ROUT, 1); push_exp(3, S_BOUT, 1);
    tick(6);
    lin = 1'b0; tin = 1'b0;
    tick(6);
    lin = 1'b1;
    push_exp(0, S_ROUT, 0); push_exp(1, S_ROUT, 1);
    tick(2);
    lin = 1'b0;
    tick(6);

    // vh=1, w=4: vertical path modulated, tin disagrees with lin -> 5 cycles
    vh = 1'b1;
    wr(4, 1'b1);
    tin = 1'b1;
    push_exp(4, S_BOUT, 0); push_exp(5, S_BOUT, 1);
    tick(6);
    tin = 1'b0; vh = 1'b0;
    tick(6);

    // Shorted cell: rin rise -> tout falls after 2 cycles
    rin = 1'b1;
    push_exp(1, S_TOUTS, 1); push_exp(2, S_TOUTS, 0);
    tick(3);
    rin = 1'b0;
    tick(3);

    // Hold: outputs forced low, weight retained
    wr(3, 1'b1);
    lin = 1'b1;
    tick(6);
    push_exp(0, S_ROUT, 1); push_exp(0, S_TOUTS, 1);
    tick(1);
    ising_rstn = 1'b0;
    push_exp(0, S_ROUT, 0); push_exp(0, S_TOUTS, 0);
    push_exp(0, S_RDC, 3);  push_exp(0, S_LOUT, 0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      lin = ~lin; rin = ~rin; tin = ~tin;
      push_exp(0, S_ROUT, 0); push_exp(0, S_TOUTS, 0);
      push_exp(0, S_BOUT, 0); push_exp(0, S_ROUTS, 0);
    end
    tick(1);
    push_exp(0, S_RDC, 3);
    tick(1);
    lin = 1'b0; rin = 1'b0; tin = 1'b0;
    ising_rstn = 1'b1;
    push_exp(0, S_TOUTS, 1); push_exp(0, S_ROUT, 0);
    wr(2, 1'b1);
    push_exp(0, S_RDC, 2);
    lin = 1'b1;
    push_exp(2, S_ROUT, 0); push_exp(3, S_ROUT, 1);
    tick(4);

    // Drain any outstanding expectations within a bounded window
    for (int i = 0; i < 10 && sb.size() > 0; i++) tick(1);
    if (sb.size() > 0) begin
      $display("FAIL drain %0d expectations never compared", sb.size());
      checks += sb.size();
      errors += sb.size();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
